// File: rtl/free_list.sv
// ---------------------------------------------------------------------------
// free_list
//   Circular FIFO of unmapped physical register tags for the rename stage.
//   Rename pops one tag per unstalled cycle from the speculative head.
//   Commit pushes released tags onto the tail and advances a retirement head
//   over tags that are now architecturally owned.
//   On recover, the speculative head snaps back to the retirement head. This
//   returns every tag that was popped but never retired.
//
// Ports
//   clk           clock; all state updates on posedge
//   reset         asynchronous, active-low reset
//   stall         front-end stall; blocks allocation only
//   alloc_req     rename wants a destination tag this cycle
//   alloc_tag     tag at the speculative head (combinational from state)
//   alloc_grant   pop accepted this cycle
//   commit_alloc  retiring instruction owned a popped tag; advances ret_head
//   commit_free   push commit_tag onto the tail
//   commit_tag    old physical mapping released by the retiring instruction
//   recover       flush: speculative head <= retirement head
//   empty         no free tag available
//   free_count    tags between speculative head and tail, 0..DEPTH
//   err           sticky overflow/underflow flag, cleared only by reset
// ---------------------------------------------------------------------------
module free_list #(
    parameter int PHYS_REGS = 64,
    parameter int ARCH_REGS = 32,
    parameter int DEPTH     = 32,
    parameter int TAG_W     = $clog2(PHYS_REGS),
    parameter int IDX_W     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             alloc_req,
    output logic [TAG_W-1:0] alloc_tag,
    output logic             alloc_grant,
    input  logic             commit_alloc,
    input  logic             commit_free,
    input  logic [TAG_W-1:0] commit_tag,
    input  logic             recover,
    output logic             empty,
    output logic [IDX_W:0]   free_count,
    output logic             err
);

    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);

    logic [TAG_W-1:0] tag_buf [DEPTH];
    logic [PTR_W-1:0] spec_head;
    logic [PTR_W-1:0] ret_head;
    logic [PTR_W-1:0] tail;

    logic [PTR_W-1:0] ret_head_next;
    logic [PTR_W-1:0] ret_count_next;
    logic             retire_ok;
    logic             push_ok;

    // Occupancy seen by rename, and the pop handshake. A pop is refused
    // while recovering, because the head is being rewritten that cycle.
    always_comb begin
        free_count  = tail - spec_head;
        empty       = (free_count == '0);
        alloc_tag   = tag_buf[spec_head[IDX_W-1:0]];
        alloc_grant = alloc_req & ~stall & ~empty & ~recover;
    end

    // Retire may only advance over tags that were actually popped. A push
    // is checked against the retirement head after this cycle's retire.
    // The slot a retire frees is the one the tail would overwrite when the
    // list is otherwise full, so the push and the retire can share a cycle.
    always_comb begin
        retire_ok      = commit_alloc & (ret_head != spec_head);
        ret_head_next  = ret_head + PTR_W'(retire_ok);
        ret_count_next = tail - ret_head_next;
        push_ok        = commit_free & (ret_count_next < DEPTH_P);
    end

    // Pointer and error state. Recover takes ret_head_next, so a retire
    // in the same cycle is not lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            spec_head <= '0;
            ret_head  <= '0;
            tail      <= DEPTH_P;
            err       <= 1'b0;
        end else begin
            ret_head <= ret_head_next;
            if (recover) begin
                spec_head <= ret_head_next;
            end else if (alloc_grant) begin
                spec_head <= spec_head + 1'b1;
            end
            if (push_ok) begin
                tail <= tail + 1'b1;
            end
            if ((commit_free & ~push_ok) | (commit_alloc & ~retire_ok)) begin
                err <= 1'b1;
            end
        end
    end

    // Tag storage. The reset image holds every physical register that is
    // not mapped by the architectural map at reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tag_buf[i] <= TAG_W'(ARCH_REGS + i);
            end
        end else if (push_ok) begin
            tag_buf[tail[IDX_W-1:0]] <= commit_tag;
        end
    end

endmodule
